// File: rtl/riscv_definitions_pkg.sv
// riscv_definitions: shared instruction-bus types and constants
// Contents:
//   dataBus_t - 32-bit instruction/data word
//   NOP_INSTR - canonical RISC-V NOP (addi x0, x0, 0)
package riscv_definitions;

    typedef logic [31:0] dataBus_t;

    localparam dataBus_t NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 storage with one synchronous write and one synchronous read port
// Ports:
//   clk     - clock
//   we_i    - write strobe
//   widx_i  - write word index
//   wdata_i - write word
//   re_i    - read strobe, captures mem[ridx_i] into rdata_o
//   ridx_i  - read word index
//   rdata_o - registered read word (read-before-write on a shared index)
import riscv_definitions::*;

module imem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] widx_i,
    input  dataBus_t                 wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] ridx_i,
    output dataBus_t                 rdata_o
);

    dataBus_t mem_q [DEPTH];
    dataBus_t rdata_q;

    assign rdata_o = rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[widx_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[ridx_i];
    end

endmodule

// File: rtl/instr_mem_model.sv
// instr_mem_model: instruction memory with fixed-latency fetch FSM, range checking and fetch counter
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   i_inst_rd_en   - fetch request
//   i_inst_addr    - fetch byte address
//   o_instr_ready  - one-cycle response pulse
//   o_instr_data   - fetched word (NOP_INSTR on error), held between responses
//   o_err          - response address misaligned or out of range
//   i_load_en      - program-load write strobe
//   i_load_idx     - word index to write
//   i_load_data    - word to write
//   o_fetch_cnt    - completed response count, wraps
import riscv_definitions::*;

module instr_mem_model #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_inst_rd_en,
    input  logic [31:0]              i_inst_addr,
    output logic                     o_instr_ready,
    output dataBus_t                 o_instr_data,
    output logic                     o_err,
    input  logic                     i_load_en,
    input  logic [$clog2(DEPTH)-1:0] i_load_idx,
    input  dataBus_t                 i_load_data,
    output logic [31:0]              o_fetch_cnt
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [3:0]  wcnt_q;
    logic        ready_q;
    dataBus_t    data_q;
    logic        err_q;
    logic [31:0] cnt_q;

    logic        accept;
    logic        enter_resp;
    logic [31:0] rd_off;
    logic [31:0] off;
    logic        in_rng;
    dataBus_t    rdata;

    // With no wait states the word is read on the accepting edge, so the
    // live address is used; otherwise the latched one is.
    assign accept     = state_q != WAIT && i_inst_rd_en;
    assign enter_resp = WAIT_STATES == 0 ? accept : state_q == WAIT && wcnt_q == 4'd0;
    assign rd_off     = (state_q == WAIT ? addr_q : i_inst_addr) - BASE_ADDR;
    assign off        = addr_q - BASE_ADDR;
    assign in_rng     = addr_q[1:0] == 2'b00 && off < SPAN;

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (i_load_en),
        .widx_i  (i_load_idx),
        .wdata_i (i_load_data),
        .re_i    (enter_resp),
        .ridx_i  (AW'(rd_off >> 2)),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 32'(ready_q);
            ready_q <= state_q == RESP;
            err_q   <= state_q == RESP && !in_rng;
            if (state_q == RESP) data_q <= in_rng ? rdata : NOP_INSTR;
            if (accept) begin
                addr_q  <= i_inst_addr;
                state_q <= WAIT_STATES == 0 ? RESP : WAIT;
                wcnt_q  <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if (state_q == WAIT) begin
                state_q <= wcnt_q == 4'd0 ? RESP : WAIT;
                wcnt_q  <= wcnt_q == 4'd0 ? 4'd0 : wcnt_q - 4'd1;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign o_instr_ready = ready_q;
    assign o_instr_data  = data_q;
    assign o_err         = err_q;
    assign o_fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_mem_model.sv
// tb_instr_mem_model: four parameterisations driven in parallel and checked against a transaction-level model
import riscv_definitions::*;

module tb_instr_mem_model;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [31:0] addr;
    logic        load_en;
    logic [5:0]  load_idx;
    logic [31:0] load_data;

    logic        rdy [4];
    logic [31:0] dat [4];
    logic        err [4];
    logic [31:0] cnt [4];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] prog [4];

    int          nacc [4];
    bit          pv   [4];
    int          ps   [4];
    int          pr   [4];
    logic [31:0] pa   [4];
    logic [31:0] pw   [4];
    logic        e_rdy [4];
    logic [31:0] e_dat [4];
    logic        e_err [4];
    logic [31:0] e_cnt [4];

    instr_mem_model #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .i_inst_rd_en(rd_en), .i_inst_addr(addr),
        .o_instr_ready(rdy[0]), .o_instr_data(dat[0]), .o_err(err[0]),
        .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data), .o_fetch_cnt(cnt[0]));
    instr_mem_model #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .i_inst_rd_en(rd_en), .i_inst_addr(addr),
        .o_instr_ready(rdy[1]), .o_instr_data(dat[1]), .o_err(err[1]),
        .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data), .o_fetch_cnt(cnt[1]));
    instr_mem_model #(.DEPTH(DEPTH), .WAIT_STATES(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .i_inst_rd_en(rd_en), .i_inst_addr(addr),
        .o_instr_ready(rdy[2]), .o_instr_data(dat[2]), .o_err(err[2]),
        .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data), .o_fetch_cnt(cnt[2]));
    instr_mem_model #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) u_db (
        .clk(clk), .rst_n(rst_n), .i_inst_rd_en(rd_en), .i_inst_addr(addr),
        .o_instr_ready(rdy[3]), .o_instr_data(dat[3]), .o_err(err[3]),
        .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data), .o_fetch_cnt(cnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws(input int d);
        return d == 1 ? 3 : d == 2 ? 5 : 0;
    endfunction

    function automatic logic [31:0] base(input int d);
        return d == 3 ? 32'h8000_0000 : 32'h0;
    endfunction

    function automatic bit inr(input int d, input logic [31:0] a);
        logic [31:0] o;
        o = a - base(d);
        return a[1:0] == 2'b00 && o < 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] word_at(input int d, input logic [31:0] a);
        logic [31:0] o;
        o = a - base(d);
        return mem[o[7:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A request accepted at edge e reads the array at edge e+W and is
    // answered in the cycle after edge e+W+1; the next one can be taken then.
    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                e_rdy[d] = 0; e_dat[d] = 0; e_err[d] = 0; e_cnt[d] = 0;
                pv[d] = 0; nacc[d] = cyc + 1;
            end else begin
                e_cnt[d] = e_cnt[d] + 32'(e_rdy[d]);
                if (pv[d] && cyc == pr[d]) begin
                    e_rdy[d] = 1;
                    e_err[d] = !inr(d, pa[d]);
                    e_dat[d] = inr(d, pa[d]) ? pw[d] : NOP_INSTR;
                    pv[d] = 0;
                end else begin
                    e_rdy[d] = 0;
                    e_err[d] = 0;
                end
                if (pv[d] && cyc == ps[d]) pw[d] = word_at(d, pa[d]);
                if (rd_en && cyc >= nacc[d]) begin
                    pv[d] = 1; pa[d] = addr;
                    ps[d] = cyc + ws(d); pr[d] = ps[d] + 1; nacc[d] = pr[d];
                    if (ws(d) == 0) pw[d] = word_at(d, addr);
                end
            end
        end
        if (load_en) mem[load_idx] = load_data;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("d%0d_rdy", d), 32'(rdy[d]), 32'(e_rdy[d]));
            chk($sformatf("d%0d_err", d), 32'(err[d]), 32'(e_err[d]));
            chk($sformatf("d%0d_data", d), dat[d], e_dat[d]);
            chk($sformatf("d%0d_cnt", d), cnt[d], e_cnt[d]);
        end
        cyc++;
    endtask

    task automatic probe(input int d, input logic [31:0] a, input logic [31:0] ed, input logic ee,
                         input logic ld, input logic [31:0] a2, input string tag);
        bit got;
        rd_en = 1; addr = a; load_en = ld; load_idx = 6'd1; load_data = 32'hDEADBEEF;
        step();
        rd_en = 0; load_en = 0; addr = a2;
        got = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (!got && rdy[d]) begin
                got = 1;
                chk({tag, "_lat"}, 32'(i), 32'(ws(d) + 1));
                chk({tag, "_data"}, dat[d], ed);
                chk({tag, "_err"}, 32'(err[d]), 32'(ee));
            end
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        logic [31:0] q0 [$];
        bit seen;
        prog[0] = 32'h0000a2b7; prog[1] = 32'h00010317;
        prog[2] = 32'h00a10093; prog[3] = 32'h0ff24193;
        for (int d = 0; d < 4; d++) begin
            e_rdy[d] = 0; e_dat[d] = 0; e_err[d] = 0; e_cnt[d] = 0; pv[d] = 0; nacc[d] = 0;
        end
        rst_n = 0; rd_en = 1; addr = 0; load_en = 0; load_idx = 0; load_data = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_idx = 6'(i); load_data = i < 4 ? prog[i] : $urandom;
            step();
        end
        load_en = 0; rd_en = 0; rst_n = 1;
        step();

        for (int i = 0; i < 12; i++) begin
            rd_en = i < 4; addr = 32'(i * 4);
            step();
            if (rdy[0]) q0.push_back(dat[0]);
        end
        rd_en = 0;
        chk("burst_count", 32'(q0.size()), 32'd4);
        for (int i = 0; i < 4 && i < q0.size(); i++) chk($sformatf("burst_w%0d", i), q0[i], prog[i]);
        chk("burst_fetch_cnt", cnt[0], 32'd4);

        probe(1, 32'h4, 32'h00010317, 0, 0, 32'h8, "wait3");
        probe(0, 32'h2, NOP_INSTR, 1, 0, 32'h0, "misalign");
        probe(0, 32'(DEPTH * 4), NOP_INSTR, 1, 0, 32'h0, "oor");
        probe(3, 32'h0, NOP_INSTR, 1, 0, 32'h0, "base_oor");
        probe(3, 32'h8000_0008, prog[2], 0, 0, 32'h0, "base_ok");
        probe(0, 32'h4, 32'h00010317, 0, 1, 32'h4, "coll_old");
        probe(0, 32'h4, 32'hDEADBEEF, 0, 0, 32'h4, "coll_new");

        rd_en = 1; addr = 0;
        step();
        rd_en = 0;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy[2]) seen = 1;
        end
        chk("rst_abort_rdy", 32'(seen), 32'd0);
        chk("rst_abort_cnt", cnt[2], 32'd0);
        probe(2, 32'h0, prog[0], 0, 0, 32'h0, "post_rst");

        u_d0.cnt_q = 32'hFFFF_FFFF;
        e_cnt[0] = 32'hFFFF_FFFF;
        probe(0, 32'h8, prog[2], 0, 0, 32'h0, "wrap");
        chk("wrap_cnt", cnt[0], 32'd0);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom % 8);
            rd_en = ($urandom % 10) < 6;
            addr = r < 5 ? {$urandom % 64, 2'b00} :
                   r == 5 ? 32'h8000_0000 + {$urandom % 64, 2'b00} :
                   r == 6 ? $urandom : {$urandom % 64, 2'b00} + 32'($urandom % 3 + 1);
            load_en = ($urandom % 5) == 0;
            load_idx = 6'($urandom);
            load_data = $urandom;
            rst_n = ($urandom % 50) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_model.md
INSTR_MEM_MODEL -- requirements
Module: instr_mem_model

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words (power of two, 4..4096).
REQ-002 The module SHALL have parameter WAIT_STATES, default 0, meaning the number of idle cycles between request acceptance and response (0..15).
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-004 The module SHALL have one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-005 The module SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- i_inst_rd_en  input  1  fetch request from core
- i_inst_addr  input  32  fetch byte address
- o_instr_ready  output  1  response valid, one-cycle pulse
- o_instr_data  output  dataBus_t  fetched instruction
- o_err  output  1  response is out-of-range or misaligned, valid with o_instr_ready
- i_load_en  input  1  program-load write strobe
- i_load_idx  input  $clog2(DEPTH)  word index to write
- i_load_data  input  dataBus_t  word to write
- o_fetch_cnt  output  32  number of completed responses

Function
REQ-006 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-007 In IDLE with i_inst_rd_en=1, the module SHALL latch i_inst_addr and go to RESP if WAIT_STATES=0, otherwise to WAIT with the wait counter loaded with WAIT_STATES-1.
REQ-008 WAIT SHALL decrement the counter each cycle and go to RESP after the counter reaches 0.
REQ-009 Latency SHALL be fixed: a request accepted at edge N SHALL produce o_instr_ready=1 for exactly the cycle after edge N+1+WAIT_STATES.
REQ-010 The word read SHALL be sampled from storage on the edge entering RESP and held on o_instr_data during RESP.
REQ-011 In RESP, if i_inst_rd_en=1, a new request SHALL be accepted using the same rules as IDLE, giving one response per cycle when WAIT_STATES=0.
REQ-012 In RESP, if i_inst_rd_en=0, the FSM SHALL return to IDLE.
REQ-013 Requests SHALL be ignored in WAIT; changes to i_inst_addr after acceptance SHALL have no effect.
REQ-014 The index SHALL be computed as (addr - BASE_ADDR) >> 2 with 32-bit modular subtraction.
REQ-015 An address is in range when addr[1:0] = 0 and (addr - BASE_ADDR) < DEPTH*4.
REQ-016 For an address out of range or misaligned, o_instr_data SHALL be NOP_INSTR (32'h0000_0013) and o_err SHALL be 1.
REQ-017 For an in-range address, o_err SHALL be 0.
REQ-018 o_instr_data SHALL retain its last value outside RESP; o_err SHALL be 0 outside RESP.
REQ-019 When i_load_en=1, i_load_data SHALL be written to word i_load_idx on the clock edge, in any state.
REQ-020 A load and a read sample of the same index on the same edge SHALL return the old word.
REQ-021 o_fetch_cnt SHALL increment by 1 on every cycle with o_instr_ready=1 and SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-022 While rst_n=0 at an edge, the state SHALL become IDLE.
REQ-023 While rst_n=0 at an edge, o_instr_ready SHALL become 0, o_instr_data SHALL become 32'h0, o_err SHALL become 0, o_fetch_cnt SHALL become 0, and the wait counter SHALL become 0.
REQ-024 Storage contents SHALL NOT be cleared by reset.
REQ-025 Load writes SHALL be honoured during reset.
REQ-026 Reset asserted in WAIT or RESP SHALL abort the transaction with no o_instr_ready pulse after reset release.

Structure
REQ-027 NOP_INSTR and dataBus_t SHALL reside in the shared riscv_definitions package.
REQ-028 The state enum SHALL be local to the module.
REQ-029 Storage SHALL be one sub-module, imem_array, a DEPTH x 32 array with one synchronous write port and one synchronous read port; the FSM and counters SHALL stay in instr_mem_model.

Verification
REQ-030 WAIT_STATES=0: load words 0..3 = 32'h0000a2b7, 32'h00010317, 32'h00a10093, 32'h0ff24193; hold i_inst_rd_en=1 with addresses 0,4,8,12 -> ready high 4 consecutive cycles, data in order, o_fetch_cnt=4.
REQ-031 WAIT_STATES=3: single request to address 4 at edge N -> ready only in the cycle after edge N+4, data 32'h00010317; address changed to 8 during WAIT has no effect.
REQ-032 Error paths -> address 32'h0000_0002 returns 32'h0000_0013 with o_err=1; address DEPTH*4 returns 32'h0000_0013 with o_err=1; BASE_ADDR=32'h8000_0000 with address 32'h0000_0000 returns o_err=1.
REQ-033 Collision: load index 1 = 32'hDEADBEEF on the same edge entering RESP for address 4 -> response returns the old word; the next fetch of address 4 returns 32'hDEADBEEF.
REQ-034 Reset mid-WAIT (WAIT_STATES=5, rst_n=0 for 1 cycle at wait cycle 2) -> no ready pulse, o_fetch_cnt=0, and a subsequent fetch of address 0 returns the preloaded word.
REQ-035 Counter wrap: force o_fetch_cnt to 32'hFFFF_FFFF via hierarchical deposit, then one fetch -> o_fetch_cnt=0.
